// File: rtl/test_tx_ctrl_pkg.sv
// Shared types and constants for the test packet generator sequencer.
package test_tx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam logic [15:0] MIN_PKT_SIZE       = 16'd2;
  localparam int          DEF_TIMEOUT_CYCLES = 65535;

  function automatic logic [15:0] clamp_size(input logic [15:0] sz);
    return (sz < MIN_PKT_SIZE) ? MIN_PKT_SIZE : sz;
  endfunction

endpackage

// File: rtl/test_tx_size_sweep.sv
// Packet size sweep register: steps size by a fixed increment on each packet end,
// wrapping to the minimum on overflow or when passing the maximum.
module test_tx_size_sweep
  import test_tx_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [15:0] i_min,
  input  logic [15:0] i_max,
  input  logic [15:0] i_step,
  input  logic        i_adv,
  output logic [15:0] o_size
);

  logic [15:0] r_size, r_min, r_max, r_step;
  logic [16:0] w_sum;
  logic        w_fixed, w_wrap;
  logic [15:0] w_next;

  assign w_sum   = {1'b0, r_size} + {1'b0, r_step};
  // A degenerate range or zero step pins the size at the minimum.
  assign w_fixed = (r_max < r_min) || (r_step == 16'd0);
  assign w_wrap  = w_sum[16] || (w_sum[15:0] > r_max);
  assign w_next  = (w_fixed || w_wrap) ? r_min : w_sum[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_size <= '0;
      r_min  <= '0;
      r_max  <= '0;
      r_step <= '0;
    end else if (i_load) begin
      r_size <= i_min;
      r_min  <= i_min;
      r_max  <= i_max;
      r_step <= i_step;
    end else if (i_adv) begin
      r_size <= w_next;
    end
  end

  assign o_size = r_size;

endmodule

// File: rtl/test_tx_ctrl.sv
// Run sequencer for the scrambler test packet generator: counts packets, stops on
// packet boundaries, watches for stalls. Size sweep enabled by TEST_TX_CTRL_SWEEP_EN.
module test_tx_ctrl
  import test_tx_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic                 cfg_stop,
  input  logic [CNT_WIDTH-1:0] cfg_pkt_count,
  input  logic [15:0]          cfg_pkt_size_min,
  input  logic [15:0]          cfg_pkt_size_max,
  input  logic [15:0]          cfg_pkt_size_step,
  input  logic [15:0]          cfg_pause_size,
  input  logic                 mon_valid,
  input  logic                 mon_sof,
  input  logic                 mon_eof,
  output logic                 gen_start,
  output logic [15:0]          gen_pkt_size,
  output logic [15:0]          gen_pause_size,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  output logic [CNT_WIDTH-1:0] tx_pkt_cnt
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_t               r_state, w_state_nxt;
  logic                 r_gen_start, w_gen_start_nxt;
  logic                 r_busy, w_busy_nxt, r_done, w_done_nxt;
  logic                 r_err, w_err_nxt, r_stop_pend, w_stop_pend_nxt;
  logic [CNT_WIDTH-1:0] r_cfg_cnt, w_cfg_cnt_nxt, r_sof_cnt, w_sof_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_pkt_cnt, w_pkt_cnt_nxt;
  logic [15:0]          r_pause_sz, w_pause_sz_nxt, r_pause_cnt, w_pause_cnt_nxt;
  logic [WD_W-1:0]      r_wdog, w_wdog_nxt;
  logic                 w_sof, w_eof, w_load, w_adv, w_last, w_active, w_tmo;
  logic [15:0]          w_min, w_pkt_size;

  assign w_sof    = mon_valid & mon_sof;
  assign w_eof    = mon_valid & mon_eof;
  assign w_min    = clamp_size(cfg_pkt_size_min);
  assign w_load   = (r_state == ST_IDLE) & cfg_start;
  assign w_active = (r_state == ST_RUN) | (r_state == ST_DRAIN);
  assign w_adv    = w_active & w_eof;
  assign w_last   = (r_cfg_cnt != '0) && (r_sof_cnt == r_cfg_cnt - CNT_WIDTH'(1));
  // Watchdog holds cycles elapsed since the last SOF/EOF (or start).
  assign w_tmo    = w_active & ~(w_sof | w_eof) & (r_wdog == WD_LAST);

  always_comb begin
    w_state_nxt     = r_state;
    w_gen_start_nxt = r_gen_start;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_err_nxt       = r_err;
    w_stop_pend_nxt = r_stop_pend;
    w_cfg_cnt_nxt   = r_cfg_cnt;
    w_sof_cnt_nxt   = r_sof_cnt;
    w_pkt_cnt_nxt   = r_pkt_cnt;
    w_pause_sz_nxt  = r_pause_sz;
    w_pause_cnt_nxt = r_pause_cnt;
    w_wdog_nxt      = r_wdog;
    case (r_state)
      ST_IDLE: if (cfg_start) begin
        w_state_nxt     = ST_RUN;
        w_gen_start_nxt = 1'b1;
        w_busy_nxt      = 1'b1;
        w_err_nxt       = 1'b0;
        w_stop_pend_nxt = 1'b0;
        w_cfg_cnt_nxt   = cfg_pkt_count;
        w_sof_cnt_nxt   = '0;
        w_pkt_cnt_nxt   = '0;
        w_pause_sz_nxt  = cfg_pause_size;
        w_wdog_nxt      = WD_ONE;
      end
      ST_RUN: begin
        w_wdog_nxt = (w_sof | w_eof) ? WD_ONE : r_wdog + WD_ONE;
        if (cfg_stop) w_stop_pend_nxt = 1'b1;
        if (w_sof)    w_sof_cnt_nxt   = r_sof_cnt + CNT_WIDTH'(1);
        if (w_eof)    w_pkt_cnt_nxt   = r_pkt_cnt + CNT_WIDTH'(1);
        // Dropping start right after SOF keeps it high through every TXSTART.
        if (w_sof && (w_last || r_stop_pend)) begin
          w_state_nxt     = ST_DRAIN;
          w_gen_start_nxt = 1'b0;
        end
      end
      ST_DRAIN: begin
        w_wdog_nxt = (w_sof | w_eof) ? WD_ONE : r_wdog + WD_ONE;
        if (w_eof) begin
          w_pkt_cnt_nxt   = r_pkt_cnt + CNT_WIDTH'(1);
          w_pause_cnt_nxt = r_pause_sz;
          w_state_nxt     = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (r_pause_cnt == 16'd0) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_pause_cnt_nxt = r_pause_cnt - 16'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_tmo) begin
      w_state_nxt     = ST_IDLE;
      w_gen_start_nxt = 1'b0;
      w_busy_nxt      = 1'b0;
      w_done_nxt      = 1'b1;
      w_err_nxt       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gen_start <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_stop_pend <= 1'b0;
      r_cfg_cnt   <= '0;
      r_sof_cnt   <= '0;
      r_pkt_cnt   <= '0;
      r_pause_sz  <= '0;
      r_pause_cnt <= '0;
      r_wdog      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gen_start <= w_gen_start_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_stop_pend <= w_stop_pend_nxt;
      r_cfg_cnt   <= w_cfg_cnt_nxt;
      r_sof_cnt   <= w_sof_cnt_nxt;
      r_pkt_cnt   <= w_pkt_cnt_nxt;
      r_pause_sz  <= w_pause_sz_nxt;
      r_pause_cnt <= w_pause_cnt_nxt;
      r_wdog      <= w_wdog_nxt;
    end
  end

`ifdef TEST_TX_CTRL_SWEEP_EN
  test_tx_size_sweep u_sweep (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_min  (w_min),
    .i_max  (cfg_pkt_size_max),
    .i_step (cfg_pkt_size_step),
    .i_adv  (w_adv),
    .o_size (w_pkt_size)
  );
`else
  logic [15:0] r_pkt_size;
  logic        w_unused_cfg;

  assign w_unused_cfg = ^{cfg_pkt_size_max, cfg_pkt_size_step, w_adv};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_pkt_size <= '0;
    else if (w_load) r_pkt_size <= w_min;
  end

  assign w_pkt_size = r_pkt_size;
`endif

  assign gen_start      = r_gen_start;
  assign gen_pkt_size   = w_pkt_size;
  assign gen_pause_size = r_pause_sz;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err_timeout    = r_err;
  assign tx_pkt_cnt     = r_pkt_cnt;

endmodule
